// File: rtl/video_capture_packer_if.sv
// Byte-stream handshake carrying packed pixel words from the capture packer
// to a host/dump consumer.
interface video_capture_packer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/video_capture_packer.sv
// Turns the board's RGB/HSYNC/VSYNC video output into a framed byte stream of
// {SOF, SOL, 000, R, G, B} words buffered in a first-word-fall-through FIFO.
module video_capture_packer #(
   parameter int FIFO_AW = 4,
   parameter int H_W     = 9,
   parameter int V_W     = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pixel_clock,
   input  logic                   red,
   input  logic                   green,
   input  logic                   blue,
   input  logic                   hsync_al,
   input  logic                   vsync_al,
   input  logic                   enable,
   input  logic                   clr_ovf,
   video_capture_packer_if.master bus,
   output logic                   overflow,
   output logic                   capturing,
   output logic [H_W-1:0]         h_count,
   output logic [V_W-1:0]         v_count,
   output logic [15:0]            frame_count
);

   localparam int DEPTH = 2 ** FIFO_AW;

   logic               pclk_q_r;
   logic               hs_q_r;
   logic               vs_q_r;
   logic               sof_pend_r;
   logic               sol_pend_r;
   logic               capturing_r;
   logic               overflow_r;
   logic               out_valid_r;
   logic [H_W-1:0]     h_count_r;
   logic [V_W-1:0]     v_count_r;
   logic [15:0]        frame_count_r;
   logic [FIFO_AW:0]   wr_ptr_r;
   logic [FIFO_AW:0]   rd_ptr_r;
   logic [7:0]         mem_r [DEPTH];

   logic               stb_s;
   logic               h_edge_s;
   logic               v_edge_s;
   logic               active_s;
   logic               empty_s;
   logic               full_s;
   logic               pop_s;
   logic               push_ok_s;
   logic               drop_s;
   logic [7:0]         word_s;
   logic [FIFO_AW:0]   wr_nxt_s;
   logic [FIFO_AW:0]   rd_nxt_s;

   // Strobe/edge detection, FIFO status and next-pointer computation
   always_comb begin
      stb_s     = pixel_clock & ~pclk_q_r;
      h_edge_s  = stb_s & hs_q_r & ~hsync_al;
      v_edge_s  = stb_s & vs_q_r & ~vsync_al;
      active_s  = stb_s & capturing_r & hsync_al & vsync_al;
      empty_s   = (wr_ptr_r == rd_ptr_r);
      full_s    = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                  (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
      // A pop frees a slot in the same cycle, so a full FIFO still takes the push
      pop_s     = ~empty_s & bus.out_ready;
      push_ok_s = active_s & (~full_s | pop_s);
      drop_s    = active_s & ~push_ok_s;
      word_s    = {sof_pend_r, sol_pend_r, 3'b000, red, green, blue};
      if (push_ok_s) begin
         wr_nxt_s = wr_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         wr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_nxt_s = rd_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         rd_nxt_s = rd_ptr_r;
      end
   end

   // Sync sampling, position counters and frame capture window
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pclk_q_r      <= 1'b1;
         hs_q_r        <= 1'b1;
         vs_q_r        <= 1'b1;
         capturing_r   <= 1'b0;
         h_count_r     <= {H_W{1'b0}};
         v_count_r     <= {V_W{1'b0}};
         frame_count_r <= 16'd0;
      end else begin
         pclk_q_r <= pixel_clock;
         if (stb_s) begin
            hs_q_r <= hsync_al;
            vs_q_r <= vsync_al;
         end
         if (v_edge_s) begin
            v_count_r     <= {V_W{1'b0}};
            frame_count_r <= frame_count_r + 16'd1;
            capturing_r   <= enable;
            if (h_edge_s) begin
               h_count_r <= {H_W{1'b0}};
            end
         end else if (h_edge_s) begin
            h_count_r <= {H_W{1'b0}};
            if (!(&v_count_r)) begin
               v_count_r <= v_count_r + {{(V_W-1){1'b0}}, 1'b1};
            end
         end else if (stb_s && hsync_al && !(&h_count_r)) begin
            h_count_r <= h_count_r + {{(H_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Markers stay pending until a word actually enters the FIFO
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sof_pend_r <= 1'b0;
         sol_pend_r <= 1'b0;
      end else begin
         if (v_edge_s) begin
            sof_pend_r <= 1'b1;
         end else if (push_ok_s) begin
            sof_pend_r <= 1'b0;
         end
         if (v_edge_s || h_edge_s) begin
            sol_pend_r <= 1'b1;
         end else if (push_ok_s) begin
            sol_pend_r <= 1'b0;
         end
      end
   end

   // FIFO pointers, registered valid flag and sticky overflow
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r    <= {(FIFO_AW+1){1'b0}};
         rd_ptr_r    <= {(FIFO_AW+1){1'b0}};
         out_valid_r <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_nxt_s;
         rd_ptr_r    <= rd_nxt_s;
         out_valid_r <= (wr_nxt_s != rd_nxt_s);
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clr_ovf) begin
            overflow_r <= 1'b0;
         end
      end
   end

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[FIFO_AW-1:0]] <= word_s;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_valid_r ? mem_r[rd_ptr_r[FIFO_AW-1:0]] : 8'h00;
   assign overflow      = overflow_r;
   assign capturing     = capturing_r;
   assign h_count       = h_count_r;
   assign v_count       = v_count_r;
   assign frame_count   = frame_count_r;

endmodule
